// File: rtl/wb_gpio_pkg.sv
// Register offsets and byte-lane helper shared by the GPIO block and its users.
// No logic: constants and one pure function only.
package wb_gpio_pkg;

  localparam logic [7:0] ADR_IN   = 8'h00;
  localparam logic [7:0] ADR_OUT  = 8'h04;
  localparam logic [7:0] ADR_OE   = 8'h08;
  localparam logic [7:0] ADR_MASK = 8'h0C;
  localparam logic [7:0] ADR_EDGE = 8'h10;
  localparam logic [7:0] ADR_PEND = 8'h14;

  // Expands the four Wishbone byte selects into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_gpio_irq_if.sv
// Peripheral Wishbone slave bus as seen by wb_gpio_irq.
// Classic single-beat handshake; the slave stretches each access by one wait state.
interface wb_gpio_irq_if;

  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_ack_o, wb_dat_o
  );

endinterface

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser with edge detect; s lags gpio_in by SYNC_STAGES cycles, rise/fall are combinational on s.
// No backpressure: samples every cycle; arm rises SYNC_STAGES+1 cycles after reset release.
module gpio_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             arm
);

  localparam logic [2:0] ARM_CNT = 3'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev;
  logic [2:0]                        cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev   <= '0;
      cnt    <= '0;
      arm    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
      prev   <= s;
      // Hold edges off until the chain has flushed out its reset zeros.
      if (!arm) begin
        if (cnt == ARM_CNT) arm <= 1'b1;
        else                cnt <= cnt + 3'd1;
      end
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev;
  assign fall = ~s & prev;

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO slave with per-pin direction and edge interrupts; 2-cycle access, intr 4 cycles after a pad edge.
// Backpressure: one wait state per access, ack never asserted on consecutive cycles.
module wb_gpio_irq
  import wb_gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  wb_gpio_irq_if.slave     bus,
  output logic             intr,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe
);

  logic             ack;
  logic             acc;
  logic [7:0]       adr;
  logic [31:0]      lane32;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] pend_q;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             arm;
  logic [31:0]      rdata;
  logic [31:0]      dat_q;
  logic             unused;

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .reset   (reset),
    .gpio_in (gpio_in),
    .s       (s),
    .rise    (rise),
    .fall    (fall),
    .arm     (arm)
  );

  assign acc    = bus.wb_stb_i & bus.wb_cyc_i & ~ack;
  assign adr    = bus.wb_adr_i[7:0];
  assign lane32 = lane_mask(bus.wb_sel_i);
  assign wmask  = lane32[WIDTH-1:0];
  assign wdat   = bus.wb_dat_i[WIDTH-1:0];
  assign unused = &{1'b0, bus.wb_adr_i[31:8], bus.wb_dat_i, lane32};

  assign bus.wb_ack_o = bus.wb_stb_i & bus.wb_cyc_i & ack;
  assign bus.wb_dat_o = dat_q;

  assign edge_hit = {WIDTH{arm}} & ((edge_q & rise) | (~edge_q & fall));
  assign clr      = (acc && bus.wb_we_i && adr == ADR_PEND) ? (wdat & wmask) : '0;

  always_comb begin
    rdata = '0;
    unique case (adr)
      ADR_IN:   rdata = 32'(s);
      ADR_OUT:  rdata = 32'(gpio_out);
      ADR_OE:   rdata = 32'(gpio_oe);
      ADR_MASK: rdata = 32'(mask_q);
      ADR_EDGE: rdata = 32'(edge_q);
      ADR_PEND: rdata = 32'(pend_q);
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack      <= 1'b0;
      dat_q    <= '0;
      intr     <= 1'b0;
      gpio_out <= '0;
      gpio_oe  <= '0;
      mask_q   <= '0;
      edge_q   <= '0;
      pend_q   <= '0;
    end else begin
      ack    <= acc;
      // A new edge beats a simultaneous clear of the same bit.
      pend_q <= (pend_q & ~clr) | edge_hit;
      intr   <= |(pend_q & mask_q);
      if (acc && !bus.wb_we_i) dat_q <= rdata;
      if (acc && bus.wb_we_i) begin
        unique case (adr)
          ADR_OUT:  gpio_out <= (gpio_out & ~wmask) | (wdat & wmask);
          ADR_OE:   gpio_oe  <= (gpio_oe  & ~wmask) | (wdat & wmask);
          ADR_MASK: mask_q   <= (mask_q   & ~wmask) | (wdat & wmask);
          ADR_EDGE: edge_q   <= (edge_q   & ~wmask) | (wdat & wmask);
          default: ;
        endcase
      end
    end
  end

endmodule
